// File: rtl/pre_if_stage.sv
// Pre-IF fetch stage: owns the fetch PC, issues one outstanding instruction
// fetch on the sram-like interface, buffers the returned word and hands
// {ex, inst, pc} to the IF stage. Redirects from exception, eret and taken
// branch discard any wrong-path fetch that is in flight or buffered.
module pre_if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allowin,
  input  logic [32:0] br_bus,
  input  logic        wb_ex,
  input  logic        eret_flush,
  input  logic [31:0] ws_epc,
  output logic        pfs_to_fs_valid,
  output logic [64:0] pfs_to_fs_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        cancel_q, cancel_d;
  logic [64:0] buf_q, buf_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        redir;
  logic [31:0] redir_target;
  logic        pc_misaligned;

  assign br_taken      = br_bus[32];
  assign br_target     = br_bus[31:0];
  assign redir         = wb_ex | eret_flush | br_taken;
  assign pc_misaligned = (fetch_pc_q[1:0] != 2'b00);

  // Redirect target: exception beats eret beats branch.
  always_comb begin
    redir_target = br_target;
    if (wb_ex) begin
      redir_target = EX_ENTRY;
    end else if (eret_flush) begin
      redir_target = ws_epc;
    end
  end

  // Next-state, fetch PC, cancel and buffer update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    cancel_d   = cancel_q;
    buf_d      = buf_q;

    case (state_q)
      S_REQ: begin
        if (pc_misaligned) begin
          // A misaligned PC becomes an address-error entry without touching
          // the bus; under a redirect it would be dropped anyway, so skip it.
          if (!redir) begin
            buf_d   = {1'b1, 32'h0, fetch_pc_q};
            state_d = S_FULL;
          end
        end else if (inst_sram_addr_ok) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
          if (redir) begin
            cancel_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          state_d = S_REQ;
          if (cancel_q) begin
            cancel_d = 1'b0;
          end else if (!redir) begin
            buf_d   = {1'b0, inst_sram_rdata, req_pc_q};
            state_d = S_FULL;
          end
        end else if (redir) begin
          cancel_d = 1'b1;
        end
      end
      S_FULL: begin
        if (redir || fs_allowin) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // A redirect always wins over the sequential PC update.
    if (redir) begin
      fetch_pc_d = redir_target;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      cancel_q   <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      cancel_q   <= cancel_d;
      buf_q      <= buf_d;
    end
  end

  assign inst_sram_req   = ~reset & (state_q == S_REQ) & ~pc_misaligned;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wdata = '0;

  assign pfs_to_fs_valid = (state_q == S_FULL) & ~redir;
  assign pfs_to_fs_bus   = buf_q;

endmodule

// File: tb/tb_pre_if_stage.sv
// Self-checking bench for pre_if_stage: directed scenarios plus a randomized
// run checked against a PC-stream model of the fetch stage.
module tb_pre_if_stage;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic [31:0] EX_ENTRY = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fs_allowin = 1'b0;
  logic [32:0] br_bus = '0;
  logic        wb_ex = 1'b0;
  logic        eret_flush = 1'b0;
  logic [31:0] ws_epc = '0;
  logic        pfs_to_fs_valid;
  logic [64:0] pfs_to_fs_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  // Manual (directed) and automatic (slave model) sram responses.
  logic        auto_slave = 1'b0;
  logic        rand_slave = 1'b0;
  logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        s_addr_ok = 1'b0, s_data_ok = 1'b0;
  logic [31:0] s_rdata = '0;

  assign inst_sram_addr_ok = auto_slave ? s_addr_ok : m_addr_ok;
  assign inst_sram_data_ok = auto_slave ? s_data_ok : m_data_ok;
  assign inst_sram_rdata   = auto_slave ? s_rdata   : m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  pre_if_stage #(.RESET_PC(RESET_PC), .EX_ENTRY(EX_ENTRY)) dut (
    .clk               (clk),
    .reset             (reset),
    .fs_allowin        (fs_allowin),
    .br_bus            (br_bus),
    .wb_ex             (wb_ex),
    .eret_flush        (eret_flush),
    .ws_epc            (ws_epc),
    .pfs_to_fs_valid   (pfs_to_fs_valid),
    .pfs_to_fs_bus     (pfs_to_fs_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a function of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  // Slave model: accepts requests (always, or randomly) and returns data
  // after 1..3 cycles.
  logic        sl_acc;
  logic [31:0] sl_acc_addr;
  logic        sl_pend = 1'b0;
  logic [31:0] sl_paddr = '0;
  int          sl_cnt = 0;
  always @(posedge clk) begin
    sl_acc      = inst_sram_req && inst_sram_addr_ok;
    sl_acc_addr = inst_sram_addr;
    #1;
    if (!auto_slave || reset) begin
      sl_pend   = 1'b0;
      s_addr_ok = 1'b0;
      s_data_ok = 1'b0;
    end else begin
      s_data_ok = 1'b0;
      if (sl_acc) begin
        sl_pend  = 1'b1;
        sl_paddr = sl_acc_addr;
        sl_cnt   = rand_slave ? int'($urandom_range(0, 2)) : 0;
      end
      if (sl_pend) begin
        if (sl_cnt == 0) begin
          s_data_ok = 1'b1;
          s_rdata   = mem(sl_paddr);
          sl_pend   = 1'b0;
        end else begin
          sl_cnt = sl_cnt - 1;
        end
      end
      s_addr_ok = inst_sram_req && (!rand_slave || ($urandom_range(0, 1) == 1));
    end
  end

  // Start of a cycle: one time unit after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    auto_slave = 1'b0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    br_bus = '0; wb_ex = 1'b0; eret_flush = 1'b0; fs_allowin = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", inst_sram_req); end
    n_checks++;
    if (pfs_to_fs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pfs_to_fs_valid); end
    n_checks++;
    if (pfs_to_fs_bus !== 65'h0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", pfs_to_fs_bus); end
    n_checks++;
    if ({inst_sram_wr, inst_sram_size, inst_sram_wdata} !== {1'b0, 2'd2, 32'h0}) begin
      n_fail++; $display("FAIL const_outputs: got wr=%b size=%0d wdata=%h expected 0/2/0", inst_sram_wr, inst_sram_size, inst_sram_wdata);
    end
    auto_slave = 1'b1;
    rand_slave = 1'b0;
    cyc();
    reset = 1'b0;
    #2;
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, RESET_PC}) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h expected 1 %h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
  endtask

  task automatic test_basic_fetch();
    logic [31:0] exp_req, exp_dpc;
    int acc_cyc, n_del;
    exp_req = RESET_PC; exp_dpc = RESET_PC; acc_cyc = -100; n_del = 0;
    fs_allowin = 1'b1;
    #2;
    for (int c = 0; c < 30 && n_del < 3; c++) begin
      if (c > 0) begin cyc(); #2; end
      if (pfs_to_fs_valid) begin
        n_checks++;
        if (pfs_to_fs_bus !== {1'b0, mem(exp_dpc), exp_dpc}) begin
          n_fail++; $display("FAIL basic_bus: got %h expected %h", pfs_to_fs_bus, {1'b0, mem(exp_dpc), exp_dpc});
        end
        n_checks++;
        if (c - acc_cyc != 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", c - acc_cyc); end
        exp_dpc = exp_dpc + 32'd4;
        n_del++;
      end
      if (inst_sram_req && inst_sram_addr_ok) begin
        n_checks++;
        if (inst_sram_addr !== exp_req) begin n_fail++; $display("FAIL basic_addr: got %h expected %h", inst_sram_addr, exp_req); end
        exp_req = exp_req + 32'd4;
        acc_cyc = c;
      end
    end
    n_checks++;
    if (n_del != 3) begin n_fail++; $display("FAIL basic_timeout: got %0d deliveries expected 3", n_del); end
  endtask

  task automatic test_stall();
    logic [64:0] held;
    bit seen;
    seen = 1'b0;
    fs_allowin = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cyc(); #2;
      seen = pfs_to_fs_valid;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL stall_timeout: got valid=0 expected 1"); end
    held = pfs_to_fs_bus;
    for (int c = 0; c < 5; c++) begin
      cyc(); #2;
      n_checks++;
      if ({pfs_to_fs_valid, inst_sram_req, pfs_to_fs_bus} !== {2'b10, held}) begin
        n_fail++; $display("FAIL stall_hold: got valid=%b req=%b bus=%h expected 1 0 %h", pfs_to_fs_valid, inst_sram_req, pfs_to_fs_bus, held);
      end
    end
    cyc();
    fs_allowin = 1'b1;
    #2;
    n_checks++;
    if (pfs_to_fs_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b expected 1", pfs_to_fs_valid); end
    cyc(); #2;
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, held[31:0] + 32'd4}) begin
      n_fail++; $display("FAIL stall_next_req: got %b %h expected 1 %h", inst_sram_req, inst_sram_addr, held[31:0] + 32'd4);
    end
  endtask

  task automatic test_ex_in_wait();
    bit prev_acc, hit;
    logic [31:0] prev_addr;
    prev_acc = 1'b0; prev_addr = '0; hit = 1'b0;
    do_reset();
    fs_allowin = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      cyc();
      m_data_ok = prev_acc;
      m_rdata   = mem(prev_addr);
      m_addr_ok = 1'b1;
      #2;
      prev_acc  = inst_sram_req;
      prev_addr = inst_sram_addr;
      if (inst_sram_req && inst_sram_addr == 32'hbfc00010) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL ex_reach_timeout: got no req at bfc00010 expected one"); end
    cyc();
    m_addr_ok = 1'b0; m_data_ok = 1'b0; wb_ex = 1'b1;
    #2;
    n_checks++;
    if ({inst_sram_req, pfs_to_fs_valid} !== 2'b00) begin
      n_fail++; $display("FAIL ex_wait_idle: got req=%b valid=%b expected 0 0", inst_sram_req, pfs_to_fs_valid);
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      wb_ex = 1'b0;
      m_data_ok = (c == 2);
      m_rdata = mem(32'hbfc00010);
      #2;
      n_checks++;
      if ({inst_sram_req, pfs_to_fs_valid} !== 2'b00) begin
        n_fail++; $display("FAIL ex_cancel_wait: got req=%b valid=%b expected 0 0", inst_sram_req, pfs_to_fs_valid);
      end
    end
    cyc();
    m_data_ok = 1'b0;
    #2;
    n_checks++;
    if ({pfs_to_fs_valid, inst_sram_req, inst_sram_addr} !== {1'b0, 1'b1, EX_ENTRY}) begin
      n_fail++; $display("FAIL ex_redirect_req: got valid=%b req=%b addr=%h expected 0 1 %h", pfs_to_fs_valid, inst_sram_req, inst_sram_addr, EX_ENTRY);
    end
  endtask

  task automatic test_eret_full();
    cyc();
    m_addr_ok = 1'b1; fs_allowin = 1'b0;
    #2;
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, EX_ENTRY}) begin
      n_fail++; $display("FAIL eret_setup_req: got %b %h expected 1 %h", inst_sram_req, inst_sram_addr, EX_ENTRY);
    end
    cyc();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = mem(EX_ENTRY);
    cyc();
    m_data_ok = 1'b0;
    #2;
    n_checks++;
    if ({pfs_to_fs_valid, pfs_to_fs_bus} !== {1'b1, 1'b0, mem(EX_ENTRY), EX_ENTRY}) begin
      n_fail++; $display("FAIL eret_setup_full: got %b %h expected 1 %h", pfs_to_fs_valid, pfs_to_fs_bus, {1'b0, mem(EX_ENTRY), EX_ENTRY});
    end
    cyc();
    eret_flush = 1'b1; ws_epc = 32'h80001000; fs_allowin = 1'b1;
    #2;
    n_checks++;
    if (pfs_to_fs_valid !== 1'b0) begin n_fail++; $display("FAIL eret_mask_valid: got %b expected 0", pfs_to_fs_valid); end
    cyc();
    eret_flush = 1'b0;
    #2;
    n_checks++;
    if ({pfs_to_fs_valid, inst_sram_req, inst_sram_addr} !== {2'b01, 32'h80001000}) begin
      n_fail++; $display("FAIL eret_next_req: got valid=%b req=%b addr=%h expected 0 1 80001000", pfs_to_fs_valid, inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_misaligned();
    cyc();
    br_bus = {1'b1, 32'h80000002}; fs_allowin = 1'b0;
    cyc();
    br_bus = '0;
    #2;
    n_checks++;
    if ({inst_sram_req, pfs_to_fs_valid} !== 2'b00) begin
      n_fail++; $display("FAIL misalign_no_req: got req=%b valid=%b expected 0 0", inst_sram_req, pfs_to_fs_valid);
    end
    cyc(); #2;
    n_checks++;
    if ({pfs_to_fs_valid, inst_sram_req, pfs_to_fs_bus} !== {2'b10, 1'b1, 32'h0, 32'h80000002}) begin
      n_fail++; $display("FAIL misalign_ex_bus: got valid=%b req=%b bus=%h expected 1 0 1_00000000_80000002", pfs_to_fs_valid, inst_sram_req, pfs_to_fs_bus);
    end
  endtask

  task automatic test_priority_and_reset();
    cyc();
    br_bus = {1'b1, 32'h80002000};
    #2;
    n_checks++;
    if (pfs_to_fs_valid !== 1'b0) begin n_fail++; $display("FAIL prio_full_mask: got %b expected 0", pfs_to_fs_valid); end
    cyc();
    br_bus = '0;
    #2;
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'h80002000}) begin
      n_fail++; $display("FAIL prio_br_req: got %b %h expected 1 80002000", inst_sram_req, inst_sram_addr);
    end
    cyc();
    wb_ex = 1'b1; br_bus = {1'b1, 32'h80003000}; m_addr_ok = 1'b0;
    #2;
    n_checks++;
    if (inst_sram_addr !== 32'h80002000) begin n_fail++; $display("FAIL prio_addr_stable: got %h expected 80002000", inst_sram_addr); end
    cyc();
    wb_ex = 1'b0; br_bus = '0;
    #2;
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, EX_ENTRY}) begin
      n_fail++; $display("FAIL prio_ex_wins: got %b %h expected 1 %h", inst_sram_req, inst_sram_addr, EX_ENTRY);
    end
    cyc();
    m_addr_ok = 1'b1;
    cyc();
    m_addr_ok = 1'b0;
    #2;
    n_checks++;
    if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL prio_wait_no_req: got %b expected 0", inst_sram_req); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({inst_sram_req, pfs_to_fs_valid, pfs_to_fs_bus} !== {2'b00, 65'h0}) begin
      n_fail++; $display("FAIL async_reset: got req=%b valid=%b bus=%h expected 0 0 0", inst_sram_req, pfs_to_fs_valid, pfs_to_fs_bus);
    end
    cyc();
    cyc();
    reset = 1'b0;
    #2;
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, RESET_PC}) begin
      n_fail++; $display("FAIL restart_req: got %b %h expected 1 %h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
  endtask

  // Randomized run. Model: the architectural fetch stream is a PC that
  // advances by 4 per accepted request and jumps to the redirect target;
  // anything accepted before a redirect is wrong-path and must never reach IF.
  task automatic test_random();
    logic [31:0] exp_pc, slot_pc, tgt;
    bit slot_live, slot_dead, redir;
    int n_del, r;
    exp_pc = RESET_PC; slot_pc = '0; slot_live = 1'b0; slot_dead = 1'b0; n_del = 0;
    cyc();
    reset = 1'b1;
    cyc();
    auto_slave = 1'b1;
    rand_slave = 1'b1;
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c > 0) cyc();
      r = int'($urandom_range(0, 24));
      wb_ex      = (r == 0);
      eret_flush = (r == 1) || (r == 4);
      ws_epc     = $urandom() & 32'hfffffffc;
      br_bus[32] = (r == 2) || (r == 3) || (r == 4);
      br_bus[31:0] = ($urandom_range(0, 3) == 0) ? 32'hfffffff8 : ($urandom() & 32'hfffffffc);
      fs_allowin = ($urandom_range(0, 3) != 0);
      #2;
      redir = wb_ex || eret_flush || br_bus[32];
      tgt = wb_ex ? EX_ENTRY : (eret_flush ? ws_epc : br_bus[31:0]);
      if (pfs_to_fs_valid && fs_allowin) begin
        n_checks++;
        if (!slot_live || slot_dead || redir) begin
          n_fail++; $display("FAIL rand_wrong_path: got delivery pc=%h expected none (live=%b dead=%b redir=%b)", pfs_to_fs_bus[31:0], slot_live, slot_dead, redir);
        end
        n_checks++;
        if (pfs_to_fs_bus !== {1'b0, mem(slot_pc), slot_pc}) begin
          n_fail++; $display("FAIL rand_bus: got %h expected %h", pfs_to_fs_bus, {1'b0, mem(slot_pc), slot_pc});
        end
        slot_live = 1'b0;
        n_del++;
      end
      if (inst_sram_req) begin
        n_checks++;
        if (inst_sram_addr !== exp_pc) begin n_fail++; $display("FAIL rand_req_addr: got %h expected %h", inst_sram_addr, exp_pc); end
        if (inst_sram_addr_ok) begin
          slot_live = 1'b1; slot_dead = 1'b0; slot_pc = exp_pc;
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redir) begin
        exp_pc = tgt;
        slot_dead = 1'b1;
      end
    end
    cyc();
    wb_ex = 1'b0; eret_flush = 1'b0; br_bus = '0;
    n_checks++;
    if (n_del < 20) begin n_fail++; $display("FAIL rand_progress: got %0d deliveries expected at least 20", n_del); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_ex_in_wait();
    test_eret_full();
    test_misaligned();
    test_priority_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-IF fetch stage, sits directly upstream of the IF stage; owns the fetch PC.
- Issues instruction fetches on the sram-like inst interface (req/addr_ok/data_ok, one outstanding request) and buffers one returned instruction.
- Hands {ex, inst, pc} to IF under a valid/allowin handshake.
- Applies redirects from exception, eret and taken branch, discarding wrong-path fetches in flight or in the buffer.

Parameters:
RESET_PC, 32'hbfc00000, first fetch address after reset
EX_ENTRY, 32'hbfc00380, exception entry PC

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
fs_allowin  input  1  IF stage can accept an instruction this cycle
br_bus  input  33  {br_taken, br_target[31:0]} from ID
wb_ex  input  1  exception flush pulse from WB
eret_flush  input  1  eret flush pulse from WB
ws_epc  input  32  eret return PC
pfs_to_fs_valid  output  1  buffered instruction valid to IF
pfs_to_fs_bus  output  65  {ex, inst[31:0], pc[31:0]}
inst_sram_req  output  1  fetch request
inst_sram_wr  output  1  constant 0
inst_sram_size  output  2  constant 2'd2 (word)
inst_sram_addr  output  32  fetch address
inst_sram_wdata  output  32  constant 0
inst_sram_addr_ok  input  1  request accepted
inst_sram_data_ok  input  1  read data returned
inst_sram_rdata  input  32  fetched instruction

Behaviour:
- Reset (async, active-high):
  - state = S_REQ, fetch_pc = RESET_PC, cancel = 0, buffer cleared.
  - pfs_to_fs_valid = 0 and pfs_to_fs_bus = 0.
  - inst_sram_req = 0 while reset is asserted.
- Redirect:
  - redir = wb_ex | eret_flush | br_taken.
  - Target priority: wb_ex -> EX_ENTRY; else eret_flush -> ws_epc; else br_target.
  - ID contract: br_taken is asserted only after the delay-slot instruction has left this stage, so every fetch at or after the current fetch_pc is wrong-path.
- FSM:
  - S_REQ:
    - If fetch_pc[1:0] != 0: no request; load buffer {1, 32'h0, fetch_pc}; go to S_FULL.
    - Else inst_sram_req = 1 and inst_sram_addr = fetch_pc.
    - On addr_ok: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4; go to S_WAIT.
    - Address may change between cycles only while unaccepted, and only due to a redirect.
  - S_WAIT:
    - req = 0.
    - On data_ok with cancel = 0: buffer <= {0, rdata, req_pc}; go to S_FULL.
    - On data_ok with cancel = 1: drop the data, clear cancel; go to S_REQ.
  - S_FULL:
    - pfs_to_fs_valid = ~redir.
    - On fs_allowin & ~redir: transfer to IF; go to S_REQ.
- Redirect per state (redir overrides the normal fetch_pc update; fetch_pc <= target in all cases):
  - S_REQ without addr_ok: stay in S_REQ; next cycle requests target.
  - S_REQ with addr_ok the same cycle: request counted as accepted; cancel <= 1; go to S_WAIT.
  - S_WAIT without data_ok: cancel <= 1; stay in S_WAIT.
  - S_WAIT with data_ok the same cycle: data dropped; cancel stays 0; go to S_REQ.
  - S_FULL: buffer dropped, valid masked that cycle; go to S_REQ.
- Only one outstanding request; no new req until buffer is empty and there is no pending data_ok.
- A single cancel bit suffices. A second redirect during cancel only updates fetch_pc.
- PC arithmetic is modulo 2^32; 32'hfffffffc + 4 wraps to 0.
- Latency: best case req/addr_ok cycle N, data_ok N+1, pfs_to_fs_valid N+2.
- Sustained throughput: one instruction per 3 cycles.

Test Plan:
- Reset release, slave gives addr_ok immediately and data_ok next cycle, fs_allowin = 1 -> addr sequence bfc00000, bfc00004, bfc00008; bus pc/inst match; ex = 0.
- fs_allowin = 0 for 5 cycles while S_FULL -> valid held, bus stable, no req issued; release -> transfer, next req at pc + 4.
- wb_ex pulse while in S_WAIT (req at bfc00010), data_ok 3 cycles later -> data dropped, never valid; next req addr = bfc00380.
- eret_flush with ws_epc = 80001000 in S_FULL, fs_allowin = 1 the same cycle -> valid = 0 that cycle, buffer dropped, next req addr 80001000.
- br_taken with target 80000002 -> no req issued; valid with ex = 1, inst = 0, pc = 80000002.
- Simultaneous wb_ex and br_taken with addr_ok held low in S_REQ -> next req addr bfc00380 (wb_ex priority); assert reset mid-S_WAIT -> req = 0, valid = 0 immediately, fetch restarts at bfc00000.
